// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin register-file write arbiter with protected-register drop and saturating contention counter
module rf_wr_arbiter #(
  parameter int N = 8,
  parameter int R = 32,
  parameter int NREQ = 3,
  localparam int A = $clog2(R)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*A-1:0]      req_addr_i,
  input  logic signed [NREQ*N-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   wr_en_o,
  output logic [A-1:0]           rd_addr_o,
  output logic signed [N-1:0]    wd_data_o,
  output logic                   drop_o,
  output logic [7:0]             conflict_cnt_o
);
  logic [1:0] ptr, p1, p2, sel;
  logic xfer, multi, prot;
  logic [A-1:0] addr;
  always_comb begin
    p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    p2 = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    sel = req_valid_i[ptr] ? ptr : req_valid_i[p1] ? p1 : p2;
    xfer = !rst_i && req_valid_i[sel];
    req_ready_o = xfer ? NREQ'(1) << sel : '0;
    addr = req_addr_i[sel*A +: A];
    prot = addr == '0 || addr == A'(30);
    multi = (req_valid_i[0] & req_valid_i[1]) | (req_valid_i[0] & req_valid_i[2]) | (req_valid_i[1] & req_valid_i[2]);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      ptr <= '0;
      wr_en_o <= 1'b0;
      drop_o <= 1'b0;
      rd_addr_o <= '0;
      wd_data_o <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (xfer) begin
        ptr <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
        rd_addr_o <= addr;
        wd_data_o <= req_data_i[sel*N +: N];
      end
      wr_en_o <= xfer && !prot;
      drop_o <= xfer && prot;
      if (multi && conflict_cnt_o != 8'hFF) conflict_cnt_o <= conflict_cnt_o + 8'd1;
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: randomized self-checking bench for rf_wr_arbiter against a behavioural model
module tb_rf_wr_arbiter;
  localparam int N = 8;
  localparam int R = 32;
  localparam int A = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] valid = '0;
  logic [3*A-1:0] addr_in = '0;
  logic signed [3*N-1:0] data_in = '0;
  logic [2:0] ready;
  logic wr_en, drop;
  logic [A-1:0] rd_addr;
  logic signed [N-1:0] wd_data;
  logic [7:0] cnt;
  int checks = 0;
  int errors = 0;
  int m_ptr, m_cnt;
  logic m_wr, m_drop;
  logic [A-1:0] m_addr;
  logic [N-1:0] m_data;
  logic [2:0] m_grant;
  rf_wr_arbiter #(.N(N), .R(R), .NREQ(3)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_addr_i(addr_in), .req_data_i(data_in),
    .req_ready_o(ready), .wr_en_o(wr_en), .rd_addr_o(rd_addr), .wd_data_o(wd_data),
    .drop_o(drop), .conflict_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] model_grant(input logic [2:0] v, input int p);
    for (int i = 0; i < 3; i++) if (v[(p + i) % 3]) return 3'(1 << ((p + i) % 3));
    return 3'b000;
  endfunction
  function automatic logic [A-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? A'(0) : r == 1 ? A'(30) : A'($urandom_range(1, 29));
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_wr = 0; m_drop = 0; m_addr = '0; m_data = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1; valid = '0; #2; rst = 1'b0; model_reset();
  endtask
  task automatic apply(input logic [2:0] v, input logic [3*A-1:0] a, input logic [3*N-1:0] d);
    valid = v; addr_in = a; data_in = d; m_grant = model_grant(v, m_ptr); #1;
  endtask
  task automatic tick();
    int k;
    if (m_grant != 3'b000) begin
      k = $clog2(m_grant);
      m_addr = addr_in[k*A +: A];
      m_data = data_in[k*N +: N];
      m_drop = m_addr == 0 || m_addr == 30;
      m_wr = !m_drop;
      m_ptr = (k + 1) % 3;
    end else begin
      m_wr = 0; m_drop = 0;
    end
    if ($countones(valid) >= 2 && m_cnt < 255) m_cnt++;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; valid = 3'b111; #3;
    checks += 6;
    if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", ready); end
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", drop); end
    if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rd_addr); end
    if (wd_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", wd_data); end
    if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    @(posedge clk); #1;
    checks += 2;
    if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt_held got %0d exp 0", cnt); end
    if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready_held got %b exp 000", ready); end
    rst = 1'b0; valid = '0; model_reset();
  endtask
  task automatic test_single();
    do_reset();
    apply(3'b001, {A'(0), A'(0), A'(5)}, {8'h00, 8'h00, 8'h3C});
    checks++;
    if (ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", ready); end
    tick();
    checks += 3;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got %b exp 1", wr_en); end
    if (rd_addr !== A'(5)) begin errors++; $display("FAIL single_addr got %0d exp 5", rd_addr); end
    if (wd_data !== 8'sh3C) begin errors++; $display("FAIL single_data got %h exp 3c", wd_data); end
    apply(3'b000, '0, '0);
    tick();
    checks += 3;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en got %b exp 0", wr_en); end
    if (rd_addr !== A'(5)) begin errors++; $display("FAIL idle_addr_hold got %0d exp 5", rd_addr); end
    if (wd_data !== 8'sh3C) begin errors++; $display("FAIL idle_data_hold got %h exp 3c", wd_data); end
  endtask
  task automatic test_round_robin();
    logic [2:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(3'b111, {A'($urandom_range(1, 29)), A'($urandom_range(1, 29)), A'($urandom_range(1, 29))}, 24'($urandom));
      exp = 3'(1 << (i % 3));
      checks++;
      if (ready !== exp) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", i, ready, exp); end
      tick();
      checks += 2;
      if (rd_addr !== m_addr || wd_data !== m_data) begin errors++; $display("FAIL rr_write%0d got %0d/%h exp %0d/%h", i, rd_addr, wd_data, m_addr, m_data); end
      if (wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en%0d got %b exp 1", i, wr_en); end
    end
    checks++;
    if (cnt !== 8'd6) begin errors++; $display("FAIL rr_conflicts got %0d exp 6", cnt); end
  endtask
  task automatic test_protected();
    do_reset();
    apply(3'b010, {A'(0), A'(30), A'(0)}, {8'h00, 8'h55, 8'h00});
    checks++;
    if (ready !== 3'b010) begin errors++; $display("FAIL prot30_ready got %b exp 010", ready); end
    tick();
    checks += 2;
    if (wr_en !== 1'b0 || drop !== 1'b1) begin errors++; $display("FAIL prot30_drop got wr=%b drop=%b exp wr=0 drop=1", wr_en, drop); end
    if (rd_addr !== A'(30)) begin errors++; $display("FAIL prot30_addr got %0d exp 30", rd_addr); end
    apply(3'b010, {A'(0), A'(0), A'(0)}, {8'h00, 8'hAA, 8'h00});
    checks++;
    if (ready !== 3'b010) begin errors++; $display("FAIL prot0_ready got %b exp 010", ready); end
    tick();
    checks++;
    if (wr_en !== 1'b0 || drop !== 1'b1) begin errors++; $display("FAIL prot0_drop got wr=%b drop=%b exp wr=0 drop=1", wr_en, drop); end
    apply(3'b111, {A'(7), A'(8), A'(9)}, {8'h01, 8'h02, 8'h03});
    checks++;
    if (ready !== 3'b100) begin errors++; $display("FAIL prot_ptr_adv got %b exp 100", ready); end
    tick();
    checks++;
    if (wr_en !== 1'b1 || drop !== 1'b0 || rd_addr !== A'(7)) begin errors++; $display("FAIL prot_after got wr=%b drop=%b addr=%0d exp 1/0/7", wr_en, drop, rd_addr); end
  endtask
  task automatic test_req2_alone();
    do_reset();
    apply(3'b100, {A'(12), A'(0), A'(0)}, {8'h80, 8'h00, 8'h00});
    checks++;
    if (ready !== 3'b100) begin errors++; $display("FAIL req2_ready got %b exp 100", ready); end
    tick();
    checks++;
    if (wr_en !== 1'b1 || rd_addr !== A'(12) || wd_data !== -8'sd128) begin errors++; $display("FAIL req2_write got %b/%0d/%h exp 1/12/80", wr_en, rd_addr, wd_data); end
    apply(3'b011, {A'(0), A'(3), A'(4)}, 24'h010203);
    checks++;
    if (ready !== 3'b001) begin errors++; $display("FAIL req2_ptr_wrap got %b exp 001", ready); end
    tick();
  endtask
  task automatic test_async_reset();
    do_reset();
    apply(3'b011, {A'(0), A'(6), A'(9)}, 24'h00_11_22);
    tick();
    checks += 2;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL ar_pre_wr got %b exp 1", wr_en); end
    if (cnt !== 8'd1) begin errors++; $display("FAIL ar_pre_cnt got %0d exp 1", cnt); end
    apply(3'b010, {A'(0), A'(6), A'(0)}, 24'h00_33_00);
    #1; rst = 1'b1; #1;
    checks += 4;
    if (wr_en !== 1'b0 || drop !== 1'b0) begin errors++; $display("FAIL ar_outputs got wr=%b drop=%b exp 0/0", wr_en, drop); end
    if (cnt !== 8'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", cnt); end
    if (ready !== 3'b000) begin errors++; $display("FAIL ar_ready got %b exp 000", ready); end
    if (rd_addr !== '0 || wd_data !== '0) begin errors++; $display("FAIL ar_regs got %0d/%h exp 0/0", rd_addr, wd_data); end
    @(posedge clk); #1;
    checks++;
    if (wr_en !== 1'b0 || drop !== 1'b0) begin errors++; $display("FAIL ar_no_write got wr=%b drop=%b exp 0/0", wr_en, drop); end
    rst = 1'b0; valid = '0; model_reset();
    apply(3'b110, {A'(4), A'(5), A'(0)}, 24'hAB_CD_00);
    checks++;
    if (ready !== 3'b010) begin errors++; $display("FAIL ar_first_grant got %b exp 010", ready); end
    tick();
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply(3'b101, {rand_addr(), rand_addr(), rand_addr()}, 24'($urandom));
      checks++;
      if (ready !== m_grant) begin errors++; $display("FAIL sat_ready%0d got %b exp %b", i, ready, m_grant); end
      tick();
      checks++;
      if (cnt !== 8'(m_cnt)) begin errors++; $display("FAIL sat_cnt%0d got %0d exp %0d", i, cnt, m_cnt); end
    end
    apply(3'b111, '0, '0);
    tick();
    checks++;
    if (cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", cnt); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      apply(3'($urandom), {rand_addr(), rand_addr(), rand_addr()}, 24'($urandom));
      checks++;
      if (ready !== m_grant) begin errors++; $display("FAIL rnd_ready%0d got %b exp %b", i, ready, m_grant); end
      tick();
      checks += 5;
      if (wr_en !== m_wr) begin errors++; $display("FAIL rnd_wr_en%0d got %b exp %b", i, wr_en, m_wr); end
      if (drop !== m_drop) begin errors++; $display("FAIL rnd_drop%0d got %b exp %b", i, drop, m_drop); end
      if (rd_addr !== m_addr) begin errors++; $display("FAIL rnd_addr%0d got %0d exp %0d", i, rd_addr, m_addr); end
      if (wd_data !== m_data) begin errors++; $display("FAIL rnd_data%0d got %h exp %h", i, wd_data, m_data); end
      if (cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt%0d got %0d exp %0d", i, cnt, m_cnt); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_protected();
    test_req2_alone();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
